// File: rtl/multicycle_pkg.sv
// Shared constants for the multicycle control block: FSM state encodings,
// instruction class codes, the halt opcode, the ALU default operation,
// datapath mux select values and fault codes.
package multicycle_pkg;

  // FSM state encodings (the state port exposes these values directly)
  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_EXEC_R   = 4'd2;
  localparam logic [3:0] ST_EXEC_I   = 4'd3;
  localparam logic [3:0] ST_ALU_WB   = 4'd4;
  localparam logic [3:0] ST_MEM_ADDR = 4'd5;
  localparam logic [3:0] ST_MEM_RD   = 4'd6;
  localparam logic [3:0] ST_MEM_WB   = 4'd7;
  localparam logic [3:0] ST_MEM_WR   = 4'd8;
  localparam logic [3:0] ST_BRANCH   = 4'd9;
  localparam logic [3:0] ST_JUMP     = 4'd10;
  localparam logic [3:0] ST_LOADI    = 4'd11;
  localparam logic [3:0] ST_HALT     = 4'd12;
  localparam logic [3:0] ST_FAULT    = 4'd13;

  // Instruction classes, taken from the top three opcode bits
  localparam logic [2:0] CLS_R   = 3'b000;
  localparam logic [2:0] CLS_I   = 3'b001;
  localparam logic [2:0] CLS_LD  = 3'b010;
  localparam logic [2:0] CLS_ST  = 3'b011;
  localparam logic [2:0] CLS_BR  = 3'b100;
  localparam logic [2:0] CLS_JMP = 3'b101;
  localparam logic [2:0] CLS_LDI = 3'b110;
  localparam logic [2:0] CLS_SYS = 3'b111;

  // Halt opcode at the default 6-bit opcode width (all ones)
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [3:0] ALU_ADD = 4'h0;

  // Register write-data select
  localparam logic [1:0] WD_MDR    = 2'd0;
  localparam logic [1:0] WD_ALUOUT = 2'd1;
  localparam logic [1:0] WD_IMM    = 2'd2;

  // ALU operand B select
  localparam logic [1:0] SRCB_FOUR    = 2'd0;
  localparam logic [1:0] SRCB_REGB    = 2'd1;
  localparam logic [1:0] SRCB_OFFS_SH = 2'd2;
  localparam logic [1:0] SRCB_OFFS    = 2'd3;

  // PC source select
  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;

  // Fault codes
  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
  localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

  // Classes whose instructions steer the register-track select
  function automatic logic uses_track(input logic [2:0] cls);
    return (cls == CLS_I) || (cls == CLS_LD) || (cls == CLS_ST) || (cls == CLS_LDI);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait.sv
// mc_mem_wait: counts stalled cycles of one memory request and flags a
// timeout.
// Ports: clk, reset (sync, active high), req (mem_req), ack (mem_ack),
//        timeout (this is the last allowed stalled cycle and no ack came),
//        done (request completes this cycle).
module mc_mem_wait #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic ack,
  output logic timeout,
  output logic done
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  // The counter holds the number of stalled cycles already seen, so the
  // cycle in which it equals MEM_TIMEOUT-1 is the one that brings the total
  // up to MEM_TIMEOUT.
  localparam logic [CW-1:0] LIMIT = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

  logic [CW-1:0] count;

  // Clearing whenever no request is pending (or it completes) means the
  // counter is already zero on entry to any waiting state.
  always_ff @(posedge clk) begin
    if (reset || !req || ack) count <= '0;
    else                      count <= count + CW'(1);
  end

  assign done    = req & ack;
  assign timeout = (MEM_TIMEOUT > 0) ? (req & ~ack & (count == LIMIT)) : 1'b0;

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle-core control FSM with merged decode, a
// variable-latency memory handshake with timeout, sticky HALT/FAULT and a
// retired-instruction counter.
// Ports: clk, reset (sync, active high), opcode (IR opcode field),
//        mem_ack (memory done); outputs state, memory strobes/selects,
//        datapath enables and selects, halted, fault_code, retired.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int OP_SIZE     = 6,
  parameter int ALU_OP_BITS = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [OP_SIZE-1:0]     opcode,
  input  logic                   mem_ack,
  output logic [3:0]             state,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic                   mem_addr_sel,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic                   reg_write,
  output logic [1:0]             reg_wdata_sel,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [ALU_OP_BITS-1:0] alu_op,
  output logic [1:0]             pc_src,
  output logic                   reg_track_sel,
  output logic                   halted,
  output logic [1:0]             fault_code,
  output logic [CNT_WIDTH-1:0]   retired
);

  logic [3:0]             next_state;
  logic [2:0]             op_class;
  logic [ALU_OP_BITS-1:0] op_alu;
  logic                   timeout;
  logic                   done;
  logic                   retire;

  assign op_class = opcode[OP_SIZE-1:OP_SIZE-3];
  assign op_alu   = opcode[ALU_OP_BITS-1:0];

  mc_mem_wait #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
    .clk    (clk),
    .reset  (reset),
    .req    (mem_req),
    .ack    (mem_ack),
    .timeout(timeout),
    .done   (done)
  );

  // Datapath controls decoded from the registered state. Strobes are
  // suppressed while reset is high so an abandoned instruction never writes.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    reg_wdata_sel = WD_MDR;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_FOUR;
    alu_op        = ALU_OP_BITS'(ALU_ADD);
    pc_src        = PCS_ALU;
    reg_track_sel = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ack;
        pc_write = mem_ack;
      end
      ST_DECODE:   alu_src_b = SRCB_OFFS_SH;
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REGB;
        alu_op    = op_alu;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_OFFS;
        alu_op    = op_alu;
      end
      ST_ALU_WB: begin
        reg_write     = 1'b1;
        reg_wdata_sel = WD_ALUOUT;
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_OFFS;
      end
      ST_MEM_RD: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
      end
      ST_MEM_WB:   reg_write = 1'b1;
      ST_MEM_WR: begin
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_addr_sel = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_REGB;
        alu_op        = op_alu;
        pc_write_cond = 1'b1;
        pc_src        = PCS_ALUOUT;
      end
      ST_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCS_JUMP;
      end
      ST_LOADI: begin
        reg_write     = 1'b1;
        reg_wdata_sel = WD_IMM;
      end
      default: ;
    endcase
    if (state != ST_HALT && state != ST_FAULT) reg_track_sel = uses_track(op_class);
    if (reset) begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      reg_write     = 1'b0;
    end
  end

  // Next-state logic; an ack always beats a timeout in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      ST_FETCH: begin
        if (done)         next_state = ST_DECODE;
        else if (timeout) next_state = ST_FAULT;
      end
      ST_DECODE: begin
        case (op_class)
          CLS_R:         next_state = ST_EXEC_R;
          CLS_I:         next_state = ST_EXEC_I;
          CLS_LD, CLS_ST: next_state = ST_MEM_ADDR;
          CLS_BR:        next_state = ST_BRANCH;
          CLS_JMP:       next_state = ST_JUMP;
          CLS_LDI:       next_state = ST_LOADI;
          CLS_SYS:       next_state = (&opcode) ? ST_HALT : ST_FAULT;
          default:       next_state = ST_FAULT;
        endcase
      end
      ST_EXEC_R, ST_EXEC_I: next_state = ST_ALU_WB;
      ST_MEM_ADDR: next_state = (op_class == CLS_LD) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD: begin
        if (done)         next_state = ST_MEM_WB;
        else if (timeout) next_state = ST_FAULT;
      end
      ST_MEM_WR: begin
        if (done)         next_state = ST_FETCH;
        else if (timeout) next_state = ST_FAULT;
      end
      ST_ALU_WB, ST_MEM_WB, ST_BRANCH, ST_JUMP, ST_LOADI: next_state = ST_FETCH;
      ST_HALT, ST_FAULT: next_state = state;
      default: next_state = ST_FETCH;
    endcase
  end

  assign retire = (state == ST_ALU_WB) || (state == ST_MEM_WB) || (state == ST_BRANCH) ||
                  (state == ST_JUMP) || (state == ST_LOADI) || ((state == ST_MEM_WR) && done);

  // State, sticky status flags and the wrapping retired counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_FETCH;
      halted     <= 1'b0;
      fault_code <= FAULT_NONE;
      retired    <= '0;
    end else begin
      state <= next_state;
      if (next_state == ST_HALT) halted <= 1'b1;
      if (state == ST_DECODE && next_state == ST_FAULT) fault_code <= FAULT_ILLEGAL;
      if (timeout) fault_code <= FAULT_TIMEOUT;
      if (retire) retired <= retired + CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Parametrised successor to the fixed 4-bit multicycle control FSM and decode pair, merged into one block.
- Adds a variable-latency memory handshake (mem_req/mem_ack) with a programmable timeout.
- Adds sticky HALT and FAULT states with a fault code, and a retired-instruction counter.
- Sits between the instruction-register opcode field and every datapath select/enable in the multicycle core.

Parameters:
- OP_SIZE, 6, opcode width; opcode[OP_SIZE-1:OP_SIZE-3] is the instruction class.
- ALU_OP_BITS, 4, ALU op width; taken from opcode[ALU_OP_BITS-1:0] for R, I and branch classes.
- MEM_TIMEOUT, 15, maximum wait cycles per memory request; 0 disables the timeout.
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- opcode  in  OP_SIZE  from the instruction register.
- mem_ack  in  1  memory done; may be high in the same cycle as mem_req.
- state  out  4  current FSM state.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe, valid with mem_req.
- mem_addr_sel  out  1  0 = PC, 1 = ALUOut.
- ir_write, pc_write, pc_write_cond, reg_write  out  1 each  enables.
- reg_wdata_sel  out  2  0 = MDR, 1 = ALUOut, 2 = big immediate.
- alu_src_a  out  1  0 = PC, 1 = regA.
- alu_src_b  out  2  0 = 4, 1 = regB, 2 = offset<<2, 3 = offset.
- alu_op  out  ALU_OP_BITS  ALU operation.
- pc_src  out  2  0 = ALU, 1 = ALUOut, 2 = jump address.
- reg_track_sel  out  1  register-track select.
- halted  out  1  sticky halt flag.
- fault_code  out  2  0 none, 1 illegal opcode, 2 memory timeout.
- retired  out  CNT_WIDTH  count of completed instructions.

Behaviour:
- Reset: state = FETCH (0); retired = 0; fault_code = 0; halted = 0; wait counter = 0.
  - While reset is high, every strobe is forced to 0, including mem_req.
  - Reset mid-instruction abandons the instruction; no write strobe fires.
- State encodings: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, ALU_WB 4, MEM_ADDR 5, MEM_RD 6, MEM_WB 7, MEM_WR 8, BRANCH 9, JUMP 10, LOADI 11, HALT 12, FAULT 13.
- Outputs are combinational from the registered state.
  - Exceptions: ir_write and pc_write in FETCH are gated by mem_ack.
  - Unlisted outputs in a state are 0; alu_op defaults to ALU_ADD.
- FETCH: mem_req=1, addr_sel=0, a=0, b=0, ADD, pc_src=0.
  - On mem_ack: ir_write=1, pc_write=1, go to DECODE.
  - Otherwise hold in FETCH.
- DECODE: a=0, b=2, ADD (precomputes the branch target into ALUOut). Next state by class:
  - 000 → EXEC_R; 001 → EXEC_I; 010 or 011 → MEM_ADDR.
  - 100 → BRANCH; 101 → JUMP; 110 → LOADI.
  - opcode == all ones → HALT; any other 111 opcode → FAULT with fault_code=1.
- EXEC_R: a=1, b=1, alu_op=opcode low bits; next ALU_WB.
- EXEC_I: a=1, b=3, alu_op=opcode low bits; next ALU_WB.
- ALU_WB: reg_write=1, wdata_sel=1; next FETCH.
- MEM_ADDR: a=1, b=3, ADD; next MEM_RD for class 010, MEM_WR for class 011.
- MEM_RD: mem_req=1, addr_sel=1; on ack → MEM_WB.
- MEM_WB: reg_write=1, wdata_sel=0; next FETCH.
- MEM_WR: mem_req=1, mem_we=1, addr_sel=1; on ack → FETCH.
- BRANCH: a=1, b=1, alu_op=opcode low bits, pc_write_cond=1, pc_src=1; next FETCH.
- JUMP: pc_write=1, pc_src=2; next FETCH.
- LOADI: reg_write=1, wdata_sel=2; next FETCH.
- reg_track_sel=1 in every state of an instruction whose class is 001, 010, 011 or 110.
- Retired count: retired increments on leaving ALU_WB, MEM_WB, MEM_WR (on ack), BRANCH, JUMP and LOADI. It wraps modulo 2^CNT_WIDTH.
- Zero-wait latencies: R/I 4 cycles, load 5, store 4, branch/jump/loadi 3.
- Timeout:
  - The wait counter clears on entry to FETCH, MEM_RD or MEM_WR, and increments each cycle mem_req=1 without mem_ack.
  - If MEM_TIMEOUT > 0 and the counter reaches MEM_TIMEOUT with no ack, go to FAULT with fault_code=2.
  - An ack in the same cycle the counter reaches MEM_TIMEOUT wins; no fault.
- HALT: halted=1, all strobes 0. HALT and FAULT are sticky until reset; mem_ack is ignored in both.

Decomposition:
- Shared package multicycle_pkg holds:
  - the state encodings;
  - the class codes (CLS_R … CLS_SYS);
  - OP_HALT;
  - ALU_ADD=4'h0;
  - the mux select constants for wdata, alu_src_b and pc_src.
- One natural sub-module: mc_mem_wait, containing the wait counter and timeout compare, with outputs timeout and done.

Test Plan:
- Reset, then R-type opcode 6'h02 with zero-wait ack → states 0,1,2,4,0; alu_op=2 in EXEC_R; reg_write for 1 cycle; retired=1.
- Load opcode 6'h10 with mem_ack delayed 3 cycles in MEM_RD → mem_req held 4 cycles, then MEM_WB with wdata_sel=0; total 8 cycles.
- MEM_TIMEOUT=15, mem_ack never asserted in FETCH → after 15 stalled cycles state=13, fault_code=2; stays there until reset; reset → state=0, fault_code=0.
- Opcode 6'h3A → FAULT with fault_code=1. Opcode 6'h3F → HALT, halted=1, no strobes for 20 cycles.
- Ack arriving exactly in the timeout cycle → DECODE, no fault. Reset asserted in MEM_WR → mem_req=0 in that cycle, state=0 next.
- CNT_WIDTH=4, 17 JUMP instructions → retired=1 (wrap); pc_src=2 and pc_write=1 in each JUMP cycle.
